// File: rtl/edgcol_dispatcher.sv
// edgcol_dispatcher: stages edge coordinates, queues submitted edges, spreads them over
// NUM_ENGINES ap_start/ap_done collision engines and returns results strictly in submit order.
`default_nettype none

module edgcol_dispatcher #(
    parameter int DATA_WIDTH   = 32,
    parameter int COORD_COUNT  = 6,
    parameter int RESULT_WIDTH = 64,
    parameter int NUM_ENGINES  = 2,
    parameter int QUEUE_DEPTH  = 4,
    parameter int TAG_WIDTH    = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      coordWrEna,
    input  logic [2:0]                                coordWrAddr,
    input  logic [DATA_WIDTH-1:0]                     coordWrData,
    input  logic                                      submitValid,
    output logic                                      submitReady,
    output logic [NUM_ENGINES-1:0]                    engStart,
    output logic [NUM_ENGINES*COORD_COUNT*DATA_WIDTH-1:0] engEdge,
    input  logic [NUM_ENGINES-1:0]                    engDone,
    input  logic [NUM_ENGINES*RESULT_WIDTH-1:0]       engResult,
    output logic                                      resValid,
    input  logic                                      resReady,
    output logic [RESULT_WIDTH-1:0]                   resData,
    output logic [TAG_WIDTH-1:0]                      resTag,
    output logic [$clog2(QUEUE_DEPTH):0]              queueCount,
    output logic                                      busy
);

    localparam int EW  = COORD_COUNT * DATA_WIDTH;
    localparam int CW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int PW  = $clog2(QUEUE_DEPTH);
    localparam int EIW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } eng_state_t;

    // Staging registers and their flattened snapshot (coordinate 0 in the LSBs)
    logic [DATA_WIDTH-1:0] r_stage [COORD_COUNT];
    logic [EW-1:0]         w_stage_flat;

    // Submit queue
    logic [EW-1:0]        r_q_edge [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0] r_q_tag  [QUEUE_DEPTH];
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_next;
    logic [TAG_WIDTH-1:0] r_seq_tag;
    logic [TAG_WIDTH-1:0] r_ret_tag;
    logic                 r_busy;

    // Engine slots
    eng_state_t            r_state  [NUM_ENGINES];
    logic [EW-1:0]         r_edge   [NUM_ENGINES];
    logic [TAG_WIDTH-1:0]  r_tag    [NUM_ENGINES];
    logic [RESULT_WIDTH-1:0] r_result [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] r_start;

    logic [NUM_ENGINES-1:0] w_idle;
    logic [NUM_ENGINES-1:0] w_ret_hit;
    logic [NUM_ENGINES-1:0] w_active_next;
    logic [EIW-1:0]         w_disp_idx;
    logic [EIW-1:0]         w_ret_idx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ret_fire;
    logic                   w_busy_next;

    always_comb begin
        w_stage_flat = '0;
        for (int c = 0; c < COORD_COUNT; c++) begin
            w_stage_flat[c*DATA_WIDTH +: DATA_WIDTH] = r_stage[c];
        end
    end

    assign submitReady = (r_count != CW'(QUEUE_DEPTH));
    assign w_push      = submitValid && submitReady;
    assign w_pop       = (r_count != '0) && (|w_idle);

    // Lowest-index IDLE engine gets the dispatch; the in-order match gets the return port
    always_comb begin
        w_idle     = '0;
        w_ret_hit  = '0;
        w_disp_idx = '0;
        w_ret_idx  = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            w_idle[i]    = (r_state[i] == S_IDLE);
            w_ret_hit[i] = (r_state[i] == S_HOLD) && (r_tag[i] == r_ret_tag);
        end
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (w_idle[i]) begin
                w_disp_idx = EIW'(i);
            end
            if (w_ret_hit[i]) begin
                w_ret_idx = EIW'(i);
            end
        end
    end

    assign resValid   = |w_ret_hit;
    assign resData    = r_result[w_ret_idx];
    assign resTag     = r_tag[w_ret_idx];
    assign w_ret_fire = resValid && resReady;

    // Next-cycle occupancy, so busy reflects the state it is registered alongside
    always_comb begin
        w_active_next = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            case (r_state[i])
                S_IDLE:  w_active_next[i] = w_pop && (w_disp_idx == EIW'(i));
                S_BUSY:  w_active_next[i] = 1'b1;
                S_HOLD:  w_active_next[i] = !(w_ret_fire && (w_ret_idx == EIW'(i)));
                default: w_active_next[i] = 1'b0;
            endcase
        end
        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        w_busy_next  = (w_count_next != '0) || (|w_active_next);
    end

    // Addresses at or beyond COORD_COUNT simply never match an index
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < COORD_COUNT; c++) begin
                r_stage[c] <= '0;
            end
        end else begin
            for (int c = 0; c < COORD_COUNT; c++) begin
                if (coordWrEna && (coordWrAddr == 3'(c))) begin
                    r_stage[c] <= coordWrData;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < QUEUE_DEPTH; q++) begin
                r_q_edge[q] <= '0;
                r_q_tag[q]  <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_seq_tag <= '0;
            r_ret_tag <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_edge[r_tail] <= w_stage_flat;
                r_q_tag[r_tail]  <= r_seq_tag;
                r_tail           <= r_tail + 1'b1;
                r_seq_tag        <= r_seq_tag + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_ret_fire) begin
                r_ret_tag <= r_ret_tag + 1'b1;
            end
            r_count <= w_count_next;
            r_busy  <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                r_state[i]  <= S_IDLE;
                r_edge[i]   <= '0;
                r_tag[i]    <= '0;
                r_result[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_pop && (w_disp_idx == EIW'(i))) begin
                            r_edge[i]  <= r_q_edge[r_head];
                            r_tag[i]   <= r_q_tag[r_head];
                            r_start[i] <= 1'b1;
                            r_state[i] <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (engDone[i]) begin
                            r_result[i] <= engResult[i*RESULT_WIDTH +: RESULT_WIDTH];
                            r_start[i]  <= 1'b0;
                            r_state[i]  <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (w_ret_fire && (w_ret_idx == EIW'(i))) begin
                            r_state[i] <= S_IDLE;
                        end
                    end
                    default: begin
                        r_start[i] <= 1'b0;
                        r_state[i] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign engStart   = r_start;
    assign queueCount = r_count;
    assign busy       = r_busy;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng_out
        assign engEdge[g*EW +: EW] = r_edge[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_edgcol_dispatcher.sv
// tb_edgcol_dispatcher: directed checks of staging, queueing, dispatch, in-order return and reset.
`default_nettype none

module tb_edgcol_dispatcher;

    localparam int NE = 2;
    localparam int EW = 6 * 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            coordWrEna = 1'b0;
    logic [2:0]      coordWrAddr = '0;
    logic [31:0]     coordWrData = '0;
    logic            submitValid = 1'b0;
    logic            submitReady;
    logic [NE-1:0]   engStart;
    logic [NE*EW-1:0] engEdge;
    logic [NE-1:0]   engDone = '0;
    logic [NE*64-1:0] engResult = '0;
    logic            resValid;
    logic            resReady = 1'b0;
    logic [63:0]     resData;
    logic [2:0]      resTag;
    logic [2:0]      queueCount;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    edgcol_dispatcher dut (
        .clk(clk), .rst(rst),
        .coordWrEna(coordWrEna), .coordWrAddr(coordWrAddr), .coordWrData(coordWrData),
        .submitValid(submitValid), .submitReady(submitReady),
        .engStart(engStart), .engEdge(engEdge),
        .engDone(engDone), .engResult(engResult),
        .resValid(resValid), .resReady(resReady), .resData(resData), .resTag(resTag),
        .queueCount(queueCount), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        coordWrEna = 1'b1; coordWrAddr = a; coordWrData = d;
        tick();
        coordWrEna = 1'b0;
    endtask

    task automatic submit();
        submitValid = 1'b1;
        tick();
        submitValid = 1'b0;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        tick();
        chk("rst_ready", 384'(submitReady), 384'd1);
        chk("rst_valid", 384'(resValid), 384'd0);
        chk("rst_start", 384'(engStart), 384'd0);
        chk("rst_count", 384'(queueCount), 384'd0);
        chk("rst_busy", 384'(busy), 384'd0);
        chk("rst_edge", 384'(engEdge), 384'd0);

        // Single edge with a 1-cycle engine
        for (int c = 0; c < 6; c++) wr(3'(c), 32'(c + 1));
        submit();
        chk("s_count_q", 384'(queueCount), 384'd1);
        chk("s_start_e0", 384'(engStart), 384'd0);
        tick();
        chk("s_start_e1", 384'(engStart), 384'b01);
        chk("s_edge0", 384'(engEdge[0 +: EW]),
            384'({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
        chk("s_busy", 384'(busy), 384'd1);
        engDone = 2'b01;
        engResult[0 +: 64] = 64'h00000000_00000001;
        tick();
        engDone = '0;
        engResult = '0;
        chk("s_valid", 384'(resValid), 384'd1);
        chk("s_tag", 384'(resTag), 384'd0);
        chk("s_data", 384'(resData), 384'd1);
        chk("s_start_off", 384'(engStart), 384'd0);
        tick();
        chk("s_hold_data", 384'(resData), 384'd1);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        chk("s_valid_off", 384'(resValid), 384'd0);

        // Out-of-order completion, in-order return
        do_reset();
        submitValid = 1'b1;
        tick();
        tick();
        submitValid = 1'b0;
        tick();
        chk("o_start", 384'(engStart), 384'b11);
        engDone = 2'b10;
        engResult[64 +: 64] = 64'hBB;
        tick();
        engDone = '0;
        chk("o_wait_b", 384'(resValid), 384'd0);
        chk("o_start_a", 384'(engStart), 384'b01);
        tick();
        chk("o_wait_b2", 384'(resValid), 384'd0);
        engDone = 2'b01;
        engResult[0 +: 64] = 64'hAA;
        tick();
        engDone = '0;
        chk("o_valid_a", 384'(resValid), 384'd1);
        chk("o_tag_a", 384'(resTag), 384'd0);
        chk("o_data_a", 384'(resData), 384'hAA);
        resReady = 1'b1;
        tick();
        chk("o_valid_b", 384'(resValid), 384'd1);
        chk("o_tag_b", 384'(resTag), 384'd1);
        chk("o_data_b", 384'(resData), 384'hBB);
        tick();
        resReady = 1'b0;
        chk("o_drained", 384'(resValid), 384'd0);
        chk("o_busy_off", 384'(busy), 384'd0);

        // Queue full with engines never done
        do_reset();
        engResult = '0;
        submitValid = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("f_ready_6", 384'(submitReady), 384'd0);
        tick();
        submitValid = 1'b0;
        chk("f_count", 384'(queueCount), 384'd4);
        chk("f_ready", 384'(submitReady), 384'd0);
        chk("f_start", 384'(engStart), 384'b11);
        tick();
        chk("f_count_hold", 384'(queueCount), 384'd4);

        // Same-cycle write and submit, out-of-range address ignored
        do_reset();
        wr(3'd0, 32'd5);
        coordWrEna = 1'b1; coordWrAddr = 3'd0; coordWrData = 32'd9;
        submitValid = 1'b1;
        tick();
        submitValid = 1'b0;
        coordWrAddr = 3'd7; coordWrData = 32'hDEAD;
        tick();
        coordWrEna = 1'b0;
        chk("w_snap", 384'(engEdge[0 +: EW]), 384'd5);
        submit();
        tick();
        chk("w_after", 384'(engEdge[EW +: EW]), 384'd9);

        // Reset while engine 0 is BUSY
        do_reset();
        submit();
        tick();
        chk("r_start_pre", 384'(engStart), 384'b01);
        do_reset();
        chk("r_start_post", 384'(engStart), 384'd0);
        engDone = 2'b01;
        engResult[0 +: 64] = 64'h55;
        tick();
        engDone = '0;
        chk("r_stale_valid", 384'(resValid), 384'd0);
        chk("r_stale_busy", 384'(busy), 384'd0);
        submit();
        tick();
        engDone = 2'b01;
        engResult[0 +: 64] = 64'h77;
        tick();
        engDone = '0;
        chk("r_valid", 384'(resValid), 384'd1);
        chk("r_tag", 384'(resTag), 384'd0);
        chk("r_data", 384'(resData), 384'h77);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        chk("r_done", 384'(resValid), 384'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
